// File: rtl/lsu_mem_if_pkg.sv
// rtl/lsu_mem_if_pkg.sv - shared funct3 codes, FSM encoding and widths for the LSU memory interface
package lsu_mem_if_pkg;

    localparam int LSU_XLEN   = 32;
    localparam int LSU_ADDR_W = 16;

    // RV32 load/store width codes (FLW/FSW reuse LSU_W)
    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_mem_if_lane_fmt.sv
// rtl/lsu_mem_if_lane_fmt.sv - byte-lane enable, legality/alignment and load formatting
//
// Purely combinational.
//   we, funct3, addr_lo : access being decoded
//   mem_rdata           : SRAM read word
//   ben                 : byte-lane enables for the access
//   legal               : funct3 is supported for this direction
//   aligned             : address is aligned to the access width
//   load_data           : selected lane, sign- or zero-extended
module lsu_mem_if_lane_fmt
    import lsu_mem_if_pkg::*;
#(
    parameter int XLEN = LSU_XLEN
) (
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [3:0]      ben,
    output logic            legal,
    output logic            aligned,
    output logic [XLEN-1:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_ext;

    assign byte_sel = mem_rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    // funct3[2] marks the unsigned load variants
    assign sign_ext = ~funct3[2];

    always_comb begin
        ben       = 4'b0000;
        legal     = 1'b0;
        aligned   = 1'b1;
        load_data = '0;
        case (funct3)
            LSU_B, LSU_BU: begin
                legal     = (funct3 == LSU_B) || !we;
                ben       = 4'b0001 << addr_lo;
                load_data = {{(XLEN-8){sign_ext & byte_sel[7]}}, byte_sel};
            end
            LSU_H, LSU_HU: begin
                legal     = (funct3 == LSU_H) || !we;
                aligned   = ~addr_lo[0];
                ben       = addr_lo[1] ? 4'b1100 : 4'b0011;
                load_data = {{(XLEN-16){sign_ext & half_sel[15]}}, half_sel};
            end
            LSU_W: begin
                legal     = 1'b1;
                aligned   = (addr_lo == 2'b00);
                ben       = 4'b1111;
                load_data = mem_rdata;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// rtl/lsu_mem_if.sv - load/store formatting stage in front of the byte-lane data SRAM
//
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   req_valid/req_ready      : request handshake from execute
//   req_we/funct3/addr/wdata : request fields
//   resp_valid               : one-cycle response pulse (no backpressure)
//   resp_rdata/misaligned/err/addr : registered response, held until next response
//   mem_addr/wdata/wen/ben   : SRAM drive, active only in ACCESS
//   mem_rdata                : SRAM combinational read word
module lsu_mem_if
    import lsu_mem_if_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int XLEN   = LSU_XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_misaligned,
    output logic              resp_err,
    output logic [XLEN-1:0]   resp_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic              mem_wen,
    output logic [3:0]        mem_ben,
    input  logic [XLEN-1:0]   mem_rdata
);

    lsu_state_e      state_q, state_d;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            accept;

    // One formatter serves both phases: in IDLE it checks the incoming
    // request, afterwards it works on the latched request.
    logic            fmt_we;
    logic [2:0]      fmt_funct3;
    logic [1:0]      fmt_addr_lo;
    logic [3:0]      fmt_ben;
    logic            fmt_legal;
    logic            fmt_aligned;
    logic [XLEN-1:0] fmt_load;

    assign fmt_we      = (state_q == IDLE) ? req_we          : we_q;
    assign fmt_funct3  = (state_q == IDLE) ? req_funct3      : funct3_q;
    assign fmt_addr_lo = (state_q == IDLE) ? req_addr[1:0]   : addr_q[1:0];

    lsu_mem_if_lane_fmt #(.XLEN(XLEN)) u_lane_fmt (
        .we        (fmt_we),
        .funct3    (fmt_funct3),
        .addr_lo   (fmt_addr_lo),
        .mem_rdata (mem_rdata),
        .ben       (fmt_ben),
        .legal     (fmt_legal),
        .aligned   (fmt_aligned),
        .load_data (fmt_load)
    );

    assign mem_addr  = addr_q[ADDR_W-1:0];
    assign mem_wdata = wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // mem_wen/mem_ben decode straight from state_q so that an asynchronous
    // reset removes the write strobe before the next edge.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        accept    = 1'b0;
        mem_wen   = 1'b0;
        mem_ben   = 4'b0000;
        case (state_q)
            IDLE: begin
                req_ready = rst_n;
                accept    = req_valid && rst_n;
                if (accept) begin
                    state_d = (fmt_legal && fmt_aligned) ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                mem_wen = we_q;
                mem_ben = fmt_ben;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q            <= 1'b0;
            funct3_q        <= 3'b000;
            addr_q          <= '0;
            wdata_q         <= '0;
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
            resp_err        <= 1'b0;
            resp_addr       <= '0;
        end else begin
            resp_valid <= 1'b0;
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                // Faults skip ACCESS and respond directly; err outranks misalignment
                if (!fmt_legal || !fmt_aligned) begin
                    resp_valid      <= 1'b1;
                    resp_err        <= ~fmt_legal;
                    resp_misaligned <= fmt_legal;
                    resp_rdata      <= '0;
                    resp_addr       <= req_addr;
                end
            end
            if (state_q == ACCESS) begin
                resp_valid      <= 1'b1;
                resp_err        <= 1'b0;
                resp_misaligned <= 1'b0;
                resp_rdata      <= we_q ? '0 : fmt_load;
                resp_addr       <= addr_q;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// tb/tb_lsu_mem_if.sv - self-checking bench for lsu_mem_if with byte-level reference memory
module tb_lsu_mem_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_err;
    logic [31:0] resp_addr;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic [3:0]  mem_ben;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_mem_if dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .resp_err        (resp_err),
        .resp_addr       (resp_addr),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wen         (mem_wen),
        .mem_ben         (mem_ben),
        .mem_rdata       (mem_rdata)
    );

    // Byte-lane SRAM: enabled lanes take consecutive bytes from the bottom of wdata
    logic [31:0] sram [0:16383];
    assign mem_rdata = sram[mem_addr[15:2]];

    always @(posedge clk) begin : sram_wr
        logic [31:0] w;
        int k;
        if (mem_wen) begin
            w = sram[mem_addr[15:2]];
            k = 0;
            for (int l = 0; l < 4; l++) begin
                if (mem_ben[l]) begin
                    w[8*l +: 8] = mem_wdata[8*k +: 8];
                    k++;
                end
            end
            sram[mem_addr[15:2]] <= w;
        end
    end

    // Reference: flat byte-addressed memory
    byte unsigned ref_mem [int];

    function automatic logic [7:0] rd_byte(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Caller is just past a negedge; leaves req_valid high on return (DUT in IDLE).
    task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int          sz, n, ma;
        bit          legal, aligned, good;
        logic [3:0]  eben;
        longint      v;
        logic [31:0] exp_rd;

        sz      = 1 << f3[1:0];
        legal   = we ? (f3 < 3'd3) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        aligned = (int'(a[2:0]) % sz) == 0;
        good    = legal && aligned;
        eben    = 4'(((1 << sz) - 1) << a[1:0]);
        ma      = int'(a[15:0]);
        exp_rd  = 32'h0;
        if (!we && good) begin
            v = 0;
            for (int i = 0; i < sz; i++) v |= longint'(rd_byte(ma + i)) << (8 * i);
            if (!f3[2] && v[8*sz-1]) v -= (longint'(1) << (8 * sz));
            exp_rd = v[31:0];
        end

        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);

        if (good) begin
            chk("acc_wen",   {31'd0, mem_wen},    {31'd0, we});
            chk("acc_ben",   {28'd0, mem_ben},    {28'd0, eben});
            chk("acc_addr",  {16'd0, mem_addr},   {16'd0, a[15:0]});
            chk("acc_wdata", mem_wdata,           wd);
            chk("acc_valid", {31'd0, resp_valid}, 32'd0);
            chk("acc_ready", {31'd0, req_ready},  32'd0);
            @(negedge clk);
        end else begin
            chk("flt_wen", {31'd0, mem_wen}, 32'd0);
            chk("flt_ben", {28'd0, mem_ben}, 32'd0);
        end

        chk("resp_valid", {31'd0, resp_valid},      32'd1);
        chk("resp_rdata", resp_rdata,               exp_rd);
        chk("resp_err",   {31'd0, resp_err},        {31'd0, !legal});
        chk("resp_mis",   {31'd0, resp_misaligned}, {31'd0, legal && !aligned});
        chk("resp_addr",  resp_addr,                a);
        chk("resp_ready", {31'd0, req_ready},       32'd0);
        chk("resp_wen",   {31'd0, mem_wen},         32'd0);

        if (we && good) begin
            for (int i = 0; i < sz; i++) ref_mem[ma + i] = wd[8*i +: 8];
        end

        @(negedge clk);
        chk("post_valid", {31'd0, resp_valid}, 32'd0);
        chk("post_ready", {31'd0, req_ready},  32'd1);
        chk("post_hold",  resp_addr,           a);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) sram[i] = 32'h0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;

        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready},  32'd0);
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata,          32'd0);
        chk("rst_wen",   {31'd0, mem_wen},    32'd0);
        chk("rst_ben",   {28'd0, mem_ben},    32'd0);
        chk("rst_maddr", {16'd0, mem_addr},   32'd0);
        chk("rst_wdata", mem_wdata,           32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", {31'd0, req_ready}, 32'd1);

        // Word store/load, byte and half lanes, misalignment, illegal funct3
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        do_req(1'b0, 3'b010, 32'h10, 32'h0);
        do_req(1'b1, 3'b000, 32'h13, 32'h000000A5);
        do_req(1'b0, 3'b000, 32'h13, 32'h0);
        do_req(1'b0, 3'b100, 32'h13, 32'h0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0);
        do_req(1'b1, 3'b001, 32'h12, 32'h00008001);
        do_req(1'b0, 3'b001, 32'h12, 32'h0);
        do_req(1'b0, 3'b101, 32'h12, 32'h0);
        do_req(1'b0, 3'b010, 32'h22, 32'h0);
        do_req(1'b1, 3'b001, 32'h11, 32'h0);
        do_req(1'b0, 3'b011, 32'h23, 32'h0);
        do_req(1'b1, 3'b100, 32'h20, 32'h11111111);
        req_valid = 1'b0;
        @(negedge clk);

        // Reset while a store is in ACCESS: write must not land
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        req_wdata  = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        chk("mid_wen_on", {31'd0, mem_wen}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_wen_off", {31'd0, mem_wen},   32'd0);
        chk("mid_ben_off", {28'd0, mem_ben},   32'd0);
        chk("mid_ready",   {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_no_resp", {31'd0, resp_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_ready", {31'd0, req_ready},  32'd1);
        chk("mid_rel_valid", {31'd0, resp_valid}, 32'd0);
        chk("mid_rel_rdata", resp_rdata,          32'd0);
        do_req(1'b0, 3'b010, 32'h40, 32'h0);

        // Randomized mix, including upper address bits beyond the SRAM range
        for (int t = 0; t < 80; t++) begin
            logic [31:0] a;
            a = 32'h100 + ($urandom % 32);
            if ($urandom_range(0, 3) == 0) a[31:16] = 16'($urandom);
            do_req(1'($urandom), 3'($urandom), a, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(1, 2)) begin
                    @(negedge clk);
                    chk("gap_valid", {31'd0, resp_valid}, 32'd0);
                end
            end
        end
        req_valid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
